reservoir_sequencer: RTL and testbench

Drives the delay-based reservoir one input sample at a time. For each sample, it issues one masked reservoir update per virtual node and waits for the reservoir's valid handshake. It then captures each node output and streams it to the readout layer. It sits between the host/DMA sample interface and the reservoir, acting as the initiator that owns the reservoir's `en`/`din` side.

---
 rtl/dfr_pkg.sv | 34 +++
 rtl/timeout_counter.sv | 38 +++
 rtl/reservoir_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_reservoir_sequencer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dfr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dfr_pkg
// Description : Shared types and helpers for the delay-based reservoir
//               front end: the sequencer state encoding, the sample width,
//               and the input masking helper.
// Revision    : 1.0 - initial release
// ============================================================================
package dfr_pkg;

    localparam int SAMPLE_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_FINISH = 2'd3
    } seq_state_t;

    // Index width that stays legal for a single-node reservoir.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Two's complement negation wraps, so -0x8000 stays 0x8000.
    function automatic logic [SAMPLE_WIDTH-1:0] apply_mask(
        input logic [SAMPLE_WIDTH-1:0] s,
        input logic                    m
    );
        return m ? s : ((~s) + SAMPLE_WIDTH'(1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/timeout_counter.sv
`default_nettype none
// ============================================================================
// Module      : timeout_counter
// Description : Counts enabled cycles and flags the cycle that would make
//               the count reach TIMEOUT_CYCLES.
// Revision    : 1.0 - initial release
// ============================================================================
module timeout_counter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int            CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // Expiry is flagged combinationally so the owner can abort on the very
    // cycle that completes the budget.
    assign expired = en && (r_count == LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr || expired) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/reservoir_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reservoir_sequencer
// Description : Feeds one host sample to the delay-based reservoir as a
//               series of masked per-node updates and streams node outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module reservoir_sequencer
    import dfr_pkg::*;
#(
    parameter int NUM_VIRTUAL_NODES = 10,
    parameter int DATA_WIDTH        = 32,
    parameter int TIMEOUT_CYCLES    = 64
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     sample_valid,
    output logic                                     sample_ready,
    input  logic [SAMPLE_WIDTH-1:0]                  sample,
    input  logic [NUM_VIRTUAL_NODES-1:0]             mask,
    output logic                                     res_en,
    output logic [DATA_WIDTH-1:0]                    res_din,
    input  logic [DATA_WIDTH-1:0]                    res_dout,
    input  logic                                     res_valid,
    output logic                                     node_valid,
    output logic [idx_width(NUM_VIRTUAL_NODES)-1:0]  node_idx,
    output logic [DATA_WIDTH-1:0]                    node_data,
    output logic                                     done,
    output logic                                     timeout_err,
    input  logic                                     clr_err
);

    localparam int               IDX_W    = idx_width(NUM_VIRTUAL_NODES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VIRTUAL_NODES - 1);

    seq_state_t                   r_state;
    seq_state_t                   w_state_next;
    logic [SAMPLE_WIDTH-1:0]      r_sample;
    logic [NUM_VIRTUAL_NODES-1:0] r_mask;
    logic [IDX_W-1:0]             r_cnt;
    logic [DATA_WIDTH-1:0]        r_din;
    logic                         r_node_valid;
    logic [IDX_W-1:0]             r_node_idx;
    logic [DATA_WIDTH-1:0]        r_node_data;
    logic                         r_done;
    logic                         r_err;

    logic                         w_accept;
    logic                         w_capture;
    logic                         w_last;
    logic                         w_tmo_en;
    logic                         w_tmo_clr;
    logic                         w_expired;
    logic [IDX_W-1:0]             w_cnt_inc;
    logic [NUM_VIRTUAL_NODES-1:0] w_next_sel;
    logic                         w_next_bit;

    assign w_accept   = sample_valid && sample_ready;
    assign w_capture  = (r_state == ST_WAIT) && res_valid;
    assign w_last     = (r_cnt == LAST_IDX);
    assign w_tmo_clr  = w_accept || res_en || w_capture;
    assign w_cnt_inc  = r_cnt + IDX_W'(1);
    assign w_next_sel = NUM_VIRTUAL_NODES'(1) << w_cnt_inc;
    assign w_next_bit = |(r_mask & w_next_sel);

    timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_tmo_clr),
        .en      (w_tmo_en),
        .expired (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (res_valid) begin
                    w_state_next = ST_WAIT;
                end else if (w_expired) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (res_valid) begin
                    w_state_next = w_last ? ST_FINISH : ST_ISSUE;
                end else if (w_expired) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_FINISH: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // A capture on the final waiting cycle takes priority over the timeout,
    // which is why the counter only runs while res_valid is low.
    always_comb begin
        sample_ready = 1'b0;
        res_en       = 1'b0;
        w_tmo_en     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                sample_ready = !rst;
            end
            ST_ISSUE: begin
                res_en   = res_valid;
                w_tmo_en = !res_valid;
            end
            ST_WAIT: begin
                w_tmo_en = !res_valid;
            end
            default: begin
                sample_ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sample     <= '0;
            r_mask       <= '0;
            r_cnt        <= '0;
            r_din        <= '0;
            r_node_valid <= 1'b0;
            r_node_idx   <= '0;
            r_node_data  <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_node_valid <= w_capture;
            r_done       <= (r_state == ST_FINISH);

            // The next node's masked input is prepared at the capture edge so
            // res_din is already stable when the following ISSUE cycle fires.
            if (w_accept) begin
                r_sample <= sample;
                r_mask   <= mask;
                r_cnt    <= '0;
                r_din    <= DATA_WIDTH'(apply_mask(sample, mask[0]));
            end else if (w_capture) begin
                r_node_data <= res_dout;
                r_node_idx  <= r_cnt;
                if (w_last) begin
                    r_din <= '0;
                end else begin
                    r_cnt <= w_cnt_inc;
                    r_din <= DATA_WIDTH'(apply_mask(r_sample, w_next_bit));
                end
            end else if (w_expired) begin
                r_din <= '0;
            end

            if (w_expired) begin
                r_err <= 1'b1;
            end else if (clr_err) begin
                r_err <= 1'b0;
            end
        end
    end

    assign res_din     = r_din;
    assign node_valid  = r_node_valid;
    assign node_idx    = r_node_idx;
    assign node_data   = r_node_data;
    assign done        = r_done;
    assign timeout_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_reservoir_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reservoir_sequencer
// Description : Directed self-checking bench with a reservoir stand-in and a
//               queue-based expectation model for reservoir_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reservoir_sequencer;

    localparam int N   = 10;
    localparam int DW  = 32;
    localparam int TMO = 8;
    localparam int IW  = $clog2(N);

    logic          clk = 1'b0;
    logic          rst;
    logic          sample_valid;
    logic          sample_ready;
    logic [15:0]   sample;
    logic [N-1:0]  mask;
    logic          res_en;
    logic [DW-1:0] res_din;
    logic [DW-1:0] res_dout;
    logic          res_valid;
    logic          node_valid;
    logic [IW-1:0] node_idx;
    logic [DW-1:0] node_data;
    logic          done;
    logic          timeout_err;
    logic          clr_err;

    reservoir_sequencer #(
        .NUM_VIRTUAL_NODES (N),
        .DATA_WIDTH        (DW),
        .TIMEOUT_CYCLES    (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample       (sample),
        .mask         (mask),
        .res_en       (res_en),
        .res_din      (res_din),
        .res_dout     (res_dout),
        .res_valid    (res_valid),
        .node_valid   (node_valid),
        .node_idx     (node_idx),
        .node_data    (node_data),
        .done         (done),
        .timeout_err  (timeout_err),
        .clr_err      (clr_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reservoir stand-in: valid drops the cycle after an update and returns
    // four cycles later; its output is a fixed scramble of the input.
    function automatic logic [DW-1:0] res_fn(input logic [DW-1:0] x);
        return {x[15:0] ^ 16'h5A5A, x[15:0]};
    endfunction

    int            busy = 0;
    int            hold = 0;
    bit            stuck = 1'b0;
    bit            stick_after_en = 1'b0;
    logic          en_seen = 1'b0;
    logic [DW-1:0] din_seen = '0;
    logic [DW-1:0] dout_q = '0;

    always @(posedge clk) begin
        #1;
        if (en_seen) begin
            busy   = 4;
            dout_q = res_fn(din_seen);
            if (stick_after_en) stuck = 1'b1;
        end else if (busy > 0) begin
            busy = busy - 1;
        end
        res_valid = (busy == 0) && !stuck && (hold == 0);
        if (hold > 0) hold = hold - 1;
        res_dout = res_valid ? dout_q : 32'hDEAD_BEEF;
    end

    // Expectation model: every sample yields N masked updates, N captures in
    // node order and one done, unless it is cut short.
    logic [DW-1:0] exp_din_q[$];
    logic [DW-1:0] exp_data_q[$];
    int            exp_idx_q[$];
    int            exp_done = 0;

    function automatic logic [DW-1:0] model_din(input logic [15:0] s, input logic m);
        int v;
        v = m ? int'(s) : ((65536 - int'(s)) % 65536);
        return DW'(v);
    endfunction

    task automatic expect_sample(input logic [15:0] s, input logic [N-1:0] m, input bit full);
        logic [DW-1:0] d;
        for (int k = 0; k < N; k++) begin
            d = model_din(s, m[k]);
            exp_din_q.push_back(d);
            if (!full) break;
            exp_idx_q.push_back(k);
            exp_data_q.push_back(res_fn(d));
        end
        if (full) exp_done++;
    endtask

    int            n_accepts = 0;
    int            n_done = 0;
    int            n_err_rise = 0;
    int            err_cycle = 0;
    logic          prev_err = 1'b0;
    int            accept_cycles[$];
    int            done_cycles[$];
    int            en_cycles[$];
    int            nv_cycles[$];
    int            idx_log[$];
    logic [DW-1:0] din_log[$];

    always @(negedge clk) begin
        en_seen  = res_en;
        din_seen = res_din;
        if (!rst) begin
            if (sample_valid && sample_ready) begin
                n_accepts++;
                accept_cycles.push_back(cyc);
            end
            if (sample_ready) check("idle_res_din", res_din, 0);
            if (res_en) begin
                en_cycles.push_back(cyc);
                din_log.push_back(res_din);
                if (exp_din_q.size() == 0) check("extra_res_en", res_en, 0);
                else check("res_din", res_din, exp_din_q.pop_front());
            end
            if (node_valid) begin
                nv_cycles.push_back(cyc);
                idx_log.push_back(int'(node_idx));
                if (exp_idx_q.size() == 0) begin
                    check("extra_node_valid", node_valid, 0);
                end else begin
                    check("node_idx", node_idx, exp_idx_q.pop_front());
                    check("node_data", node_data, exp_data_q.pop_front());
                end
            end
            if (done) begin
                n_done++;
                done_cycles.push_back(cyc);
                if (exp_done == 0) check("extra_done", done, 0);
                else exp_done--;
            end
            if (timeout_err && !prev_err) begin
                n_err_rise++;
                err_cycle = cyc;
            end
        end
        prev_err = timeout_err;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    function automatic int get_count(input int which);
        case (which)
            0:       return n_accepts;
            1:       return n_done;
            2:       return en_cycles.size();
            default: return n_err_rise;
        endcase
    endfunction

    task automatic wait_for(input int which, input int target, input int budget, input string name);
        int k;
        k = 0;
        while (get_count(which) < target && k < budget) begin
            tick(1);
            k++;
        end
        if (get_count(which) < target) begin
            checks++;
            errors++;
            $display("FAIL %s: count %0d, required %0d within %0d cycles", name, get_count(which), target, budget);
        end
    endtask

    task automatic clear_logs();
        accept_cycles.delete();
        done_cycles.delete();
        en_cycles.delete();
        nv_cycles.delete();
        idx_log.delete();
        din_log.delete();
    endtask

    task automatic check_drained(input string name);
        check({name, "_din_left"}, exp_din_q.size(), 0);
        check({name, "_node_left"}, exp_idx_q.size(), 0);
        check({name, "_done_left"}, exp_done, 0);
    endtask

    task automatic run_sample(input logic [15:0] s, input logic [N-1:0] m, input int busy_hold);
        int acc0;
        int done0;
        acc0  = n_accepts;
        done0 = n_done;
        expect_sample(s, m, 1'b1);
        sample       = s;
        mask         = m;
        sample_valid = 1'b1;
        hold         = busy_hold;
        wait_for(0, acc0 + 1, 20, "accept_wait");
        sample_valid = 1'b0;
        wait_for(1, done0 + 1, 6 * N + 40, "done_wait");
        tick(2);
    endtask

    initial begin
        int acc0;
        int done0;
        rst          = 1'b1;
        sample_valid = 1'b0;
        sample       = '0;
        mask         = '0;
        clr_err      = 1'b0;
        res_valid    = 1'b1;
        res_dout     = '0;
        tick(3);
        check("rst_sample_ready", sample_ready, 0);
        check("rst_res_en", res_en, 0);
        check("rst_node_valid", node_valid, 0);
        check("rst_done", done, 0);
        check("rst_timeout_err", timeout_err, 0);
        rst = 1'b0;
        tick(1);
        check("post_rst_ready", sample_ready, 1);

        // Nominal sample.
        clear_logs();
        run_sample(16'h0123, 10'b1010101010, 0);
        check("nom_en_count", en_cycles.size(), 10);
        check("nom_node_count", nv_cycles.size(), 10);
        if (en_cycles.size() == 10 && nv_cycles.size() == 10 && done_cycles.size() == 1) begin
            check("nom_din0", din_log[0], 32'h0000FEDD);
            check("nom_din1", din_log[1], 32'h00000123);
            check("nom_en_latency", en_cycles[0] - accept_cycles[0], 1);
            check("nom_node_after_en", nv_cycles[0] - en_cycles[0], 6);
            check("nom_idx_last", idx_log[9], 9);
            for (int k = 0; k < 9; k++) check("nom_en_gap", en_cycles[k + 1] - en_cycles[k], 6);
            check("nom_done_latency", done_cycles[0] - accept_cycles[0], 62);
        end
        check_drained("nom");

        // Reservoir busy when the first update is due.
        clear_logs();
        run_sample(16'h0F0F, 10'b0000011111, 4);
        check("busy_en_count", en_cycles.size(), 10);
        check("busy_node_count", nv_cycles.size(), 10);
        if (en_cycles.size() > 0) check("busy_en_latency", en_cycles[0] - accept_cycles[0], 5);
        check_drained("busy");

        // Timeout: reservoir never comes back after the first update.
        clear_logs();
        acc0  = n_accepts;
        done0 = n_done;
        expect_sample(16'h0042, 10'b0000000001, 1'b0);
        stick_after_en = 1'b1;
        sample         = 16'h0042;
        mask           = 10'b0000000001;
        sample_valid   = 1'b1;
        wait_for(0, acc0 + 1, 20, "tmo_accept_wait");
        sample_valid = 1'b0;
        wait_for(3, 1, 40, "tmo_err_wait");
        check("tmo_err_set", timeout_err, 1);
        check("tmo_ready_after", sample_ready, 1);
        if (en_cycles.size() > 0) check("tmo_err_latency", err_cycle - en_cycles[0], 9);
        tick(5);
        check("tmo_err_sticky", timeout_err, 1);
        check("tmo_no_done", n_done - done0, 0);
        check("tmo_no_node", nv_cycles.size(), 0);
        stick_after_en = 1'b0;
        stuck          = 1'b0;
        clr_err        = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("tmo_err_cleared", timeout_err, 0);
        check_drained("tmo");
        tick(2);

        // Negation boundary.
        clear_logs();
        run_sample(16'h8000, 10'b0000000000, 0);
        if (din_log.size() == 10) begin
            check("neg_din_8000_first", din_log[0], 32'h00008000);
            check("neg_din_8000_last", din_log[9], 32'h00008000);
        end
        clear_logs();
        run_sample(16'h0000, 10'b0000000000, 0);
        if (din_log.size() == 10) check("neg_din_zero", din_log[0], 32'h00000000);
        check_drained("neg");

        // Reset while waiting on node 4.
        clear_logs();
        acc0 = n_accepts;
        expect_sample(16'h1111, 10'b1111111111, 1'b1);
        sample       = 16'h1111;
        mask         = 10'b1111111111;
        sample_valid = 1'b1;
        wait_for(0, acc0 + 1, 20, "rst_accept_wait");
        sample_valid = 1'b0;
        wait_for(2, 5, 60, "rst_node4_wait");
        tick(2);
        rst = 1'b1;
        #1;
        check("mid_rst_res_en", res_en, 0);
        check("mid_rst_res_din", res_din, 0);
        check("mid_rst_node_valid", node_valid, 0);
        check("mid_rst_node_idx", node_idx, 0);
        check("mid_rst_node_data", node_data, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_sample_ready", sample_ready, 0);
        exp_din_q.delete();
        exp_idx_q.delete();
        exp_data_q.delete();
        exp_done = 0;
        tick(2);
        rst = 1'b0;
        tick(1);
        check("rst_release_ready", sample_ready, 1);
        clear_logs();
        run_sample(16'h2222, 10'b0101010101, 0);
        if (idx_log.size() > 0) check("rst_restart_idx0", idx_log[0], 0);
        check("rst_restart_nodes", nv_cycles.size(), 10);
        check_drained("rst");

        // Back-to-back samples with sample_valid held high.
        clear_logs();
        acc0  = n_accepts;
        done0 = n_done;
        expect_sample(16'h0042, 10'b0011110000, 1'b1);
        expect_sample(16'h7FFF, 10'b1100001111, 1'b1);
        sample       = 16'h0042;
        mask         = 10'b0011110000;
        sample_valid = 1'b1;
        wait_for(0, acc0 + 1, 20, "b2b_accept1_wait");
        sample = 16'h7FFF;
        mask   = 10'b1100001111;
        wait_for(0, acc0 + 2, 6 * N + 20, "b2b_accept2_wait");
        sample_valid = 1'b0;
        wait_for(1, done0 + 2, 6 * N + 40, "b2b_done_wait");
        tick(2);
        if (accept_cycles.size() == 2 && done_cycles.size() == 2) begin
            check("b2b_accept_after_done", accept_cycles[1] - done_cycles[0], 0);
            check("b2b_accept_spacing", accept_cycles[1] - accept_cycles[0], 62);
        end
        check("b2b_en_count", en_cycles.size(), 20);
        check_drained("b2b");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
